// File: rtl/dram_id_remap_pkg.sv
// dram_id_remap_pkg: shared helpers for the DRAM AXI ID remapper.
// Slot tables support up to MaxSlots entries (MstIdWidth <= 8).
package dram_id_remap_pkg;
  localparam int MaxSlots = 256;
  function automatic int lowest_set(input logic [MaxSlots-1:0] v);
    lowest_set = 0;
    for (int i = MaxSlots - 1; i >= 0; i--) if (v[i]) lowest_set = i;
  endfunction
endpackage

// File: rtl/dram_id_remap_dir.sv
// dram_id_remap_dir: ID slot table, grant, allocate and release for one AXI direction.
module dram_id_remap_dir
  import dram_id_remap_pkg::*;
#(
  parameter int SlvIdWidth  = 6,
  parameter int MstIdWidth  = 4,
  parameter int MaxTxnPerId = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  i_en,
  input  logic [SlvIdWidth-1:0] i_req_id,
  input  logic                  i_req_valid,
  input  logic                  i_req_ready,
  output logic                  o_req_valid,
  output logic                  o_req_ready,
  output logic [MstIdWidth-1:0] o_req_id,
  input  logic                  i_rel,
  input  logic [MstIdWidth-1:0] i_rsp_id,
  output logic [SlvIdWidth-1:0] o_rsp_id
);
  localparam int NumSlots = 2 ** MstIdWidth;
  localparam int CntW     = $clog2(MaxTxnPerId + 1);
  typedef struct packed {
    logic                  valid;
    logic [SlvIdWidth-1:0] id;
    logic [CntW-1:0]       cnt;
  } slot_t;
  slot_t                 r_tab [NumSlots];
  logic [NumSlots-1:0]   w_free, w_inc, w_dec;
  logic                  w_hit, w_grant, w_hs;
  logic [MstIdWidth-1:0] w_hit_idx, w_sel;
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = 0; i < NumSlots; i++) begin
      w_free[i] = ~r_tab[i].valid;
      if (r_tab[i].valid && r_tab[i].id == i_req_id) begin
        w_hit     = 1'b1;
        w_hit_idx = MstIdWidth'(i);
      end
    end
  end
  // an already-mapped ID always reuses its slot so same-ID ordering holds
  assign w_sel       = w_hit ? w_hit_idx : MstIdWidth'(lowest_set(MaxSlots'(w_free)));
  assign w_grant     = i_en & (w_hit ? (r_tab[w_hit_idx].cnt < CntW'(MaxTxnPerId)) : |w_free);
  assign o_req_valid = i_req_valid & w_grant;
  assign o_req_ready = i_req_ready & w_grant;
  assign o_req_id    = w_sel;
  assign w_hs        = i_req_valid & i_req_ready & w_grant;
  assign o_rsp_id    = r_tab[i_rsp_id].id;
  always_comb begin
    for (int i = 0; i < NumSlots; i++) begin
      w_inc[i] = w_hs && w_sel == MstIdWidth'(i);
      w_dec[i] = i_rel && i_rsp_id == MstIdWidth'(i) && r_tab[i].cnt != '0;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumSlots; i++) r_tab[i] <= '0;
    end else begin
      for (int i = 0; i < NumSlots; i++) begin
        if (w_inc[i] && !w_dec[i]) r_tab[i].cnt <= r_tab[i].cnt + 1'b1;
        else if (w_dec[i] && !w_inc[i]) r_tab[i].cnt <= r_tab[i].cnt - 1'b1;
        if (w_inc[i] && !r_tab[i].valid) begin
          r_tab[i].valid <= 1'b1;
          r_tab[i].id    <= i_req_id;
        end else if (w_dec[i] && !w_inc[i] && r_tab[i].cnt == CntW'(1)) begin
          r_tab[i].valid <= 1'b0;
        end
      end
    end
  end
  // responses must target a live slot with outstanding transactions
  always_ff @(posedge clk_i) begin
    if (!rst_i && i_rel) assert (r_tab[i_rsp_id].valid && r_tab[i_rsp_id].cnt != '0);
  end
endmodule

// File: rtl/dram_id_remapper.sv
// dram_id_remapper: tracked AXI ID remapping between SoC and MIG for AR/R and AW/B.
// Define DRAM_ID_REMAP_CALIB_GATE_EN to hold off all grants until MIG calibration completes.
module dram_id_remapper
  import dram_id_remap_pkg::*;
#(
  parameter int SlvIdWidth  = 6,
  parameter int MstIdWidth  = 4,
  parameter int MaxTxnPerId = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
`ifdef DRAM_ID_REMAP_CALIB_GATE_EN
  input  logic                  calib_done_i,
`endif
  input  logic [SlvIdWidth-1:0] slv_ar_id_i,
  input  logic                  slv_ar_valid_i,
  output logic                  slv_ar_ready_o,
  output logic [MstIdWidth-1:0] mst_ar_id_o,
  output logic                  mst_ar_valid_o,
  input  logic                  mst_ar_ready_i,
  input  logic [MstIdWidth-1:0] mst_r_id_i,
  input  logic                  mst_r_valid_i,
  input  logic                  mst_r_last_i,
  input  logic                  slv_r_ready_i,
  output logic [SlvIdWidth-1:0] slv_r_id_o,
  input  logic [SlvIdWidth-1:0] slv_aw_id_i,
  input  logic                  slv_aw_valid_i,
  output logic                  slv_aw_ready_o,
  output logic [MstIdWidth-1:0] mst_aw_id_o,
  output logic                  mst_aw_valid_o,
  input  logic                  mst_aw_ready_i,
  input  logic [MstIdWidth-1:0] mst_b_id_i,
  input  logic                  mst_b_valid_i,
  input  logic                  slv_b_ready_i,
  output logic [SlvIdWidth-1:0] slv_b_id_o
);
  logic w_en;
`ifdef DRAM_ID_REMAP_CALIB_GATE_EN
  logic r_calib;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_calib <= 1'b0;
    else if (calib_done_i) r_calib <= 1'b1;
  end
  assign w_en = ~rst_i & r_calib;
`else
  assign w_en = ~rst_i;
`endif
  dram_id_remap_dir #(
    .SlvIdWidth(SlvIdWidth), .MstIdWidth(MstIdWidth), .MaxTxnPerId(MaxTxnPerId)
  ) u_rd (
    .clk_i(clk_i), .rst_i(rst_i), .i_en(w_en),
    .i_req_id(slv_ar_id_i), .i_req_valid(slv_ar_valid_i), .i_req_ready(mst_ar_ready_i),
    .o_req_valid(mst_ar_valid_o), .o_req_ready(slv_ar_ready_o), .o_req_id(mst_ar_id_o),
    .i_rel(mst_r_valid_i & slv_r_ready_i & mst_r_last_i), .i_rsp_id(mst_r_id_i), .o_rsp_id(slv_r_id_o)
  );
  dram_id_remap_dir #(
    .SlvIdWidth(SlvIdWidth), .MstIdWidth(MstIdWidth), .MaxTxnPerId(MaxTxnPerId)
  ) u_wr (
    .clk_i(clk_i), .rst_i(rst_i), .i_en(w_en),
    .i_req_id(slv_aw_id_i), .i_req_valid(slv_aw_valid_i), .i_req_ready(mst_aw_ready_i),
    .o_req_valid(mst_aw_valid_o), .o_req_ready(slv_aw_ready_o), .o_req_id(mst_aw_id_o),
    .i_rel(mst_b_valid_i & slv_b_ready_i), .i_rsp_id(mst_b_id_i), .o_rsp_id(slv_b_id_o)
  );
endmodule

// File: tb/tb_dram_id_remapper.sv
// tb_dram_id_remapper: scenario tasks with a queue scoreboard of expected MIG slot IDs.
module tb_dram_id_remapper;
  logic       clk = 1'b0;
  logic       rst_i = 1'b0;
  logic       calib_done_i = 1'b1;
  logic [5:0] slv_ar_id_i = '0, slv_aw_id_i = '0;
  logic       slv_ar_valid_i = 0, slv_aw_valid_i = 0, mst_ar_ready_i = 1, mst_aw_ready_i = 1;
  logic [3:0] mst_r_id_i = '0, mst_b_id_i = '0;
  logic       mst_r_valid_i = 0, mst_r_last_i = 0, slv_r_ready_i = 1, mst_b_valid_i = 0, slv_b_ready_i = 1;
  logic       slv_ar_ready_o, mst_ar_valid_o, slv_aw_ready_o, mst_aw_valid_o;
  logic [3:0] mst_ar_id_o, mst_aw_id_o;
  logic [5:0] slv_r_id_o, slv_b_id_o;
  logic       s_ar_hs, s_aw_hs, s_ar_vld, s_aw_vld;
  logic [3:0] s_ar_id, s_aw_id, e;
  logic [5:0] s_r_id, s_b_id;
  logic [3:0] exp_q[$];
  int         n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  dram_id_remapper dut (
    .clk_i(clk), .rst_i(rst_i),
`ifdef DRAM_ID_REMAP_CALIB_GATE_EN
    .calib_done_i(calib_done_i),
`endif
    .slv_ar_id_i(slv_ar_id_i), .slv_ar_valid_i(slv_ar_valid_i), .slv_ar_ready_o(slv_ar_ready_o),
    .mst_ar_id_o(mst_ar_id_o), .mst_ar_valid_o(mst_ar_valid_o), .mst_ar_ready_i(mst_ar_ready_i),
    .mst_r_id_i(mst_r_id_i), .mst_r_valid_i(mst_r_valid_i), .mst_r_last_i(mst_r_last_i),
    .slv_r_ready_i(slv_r_ready_i), .slv_r_id_o(slv_r_id_o),
    .slv_aw_id_i(slv_aw_id_i), .slv_aw_valid_i(slv_aw_valid_i), .slv_aw_ready_o(slv_aw_ready_o),
    .mst_aw_id_o(mst_aw_id_o), .mst_aw_valid_o(mst_aw_valid_o), .mst_aw_ready_i(mst_aw_ready_i),
    .mst_b_id_i(mst_b_id_i), .mst_b_valid_i(mst_b_valid_i), .slv_b_ready_i(slv_b_ready_i),
    .slv_b_id_o(slv_b_id_o)
  );

  task automatic do_reset();
    slv_ar_valid_i = 0; slv_aw_valid_i = 0; mst_r_valid_i = 0; mst_b_valid_i = 0;
    @(negedge clk); rst_i = 1;
    repeat (2) @(negedge clk);
    rst_i = 0;
    exp_q.delete();
  endtask

  // one clock: drive at negedge, sample combinational outputs mid-low-phase, release after posedge
  task automatic cyc(input logic arv, input logic [5:0] arid, input logic awv, input logic [5:0] awid,
                     input logic rv, input logic [3:0] rid, input logic bv, input logic [3:0] bid);
    @(negedge clk);
    slv_ar_valid_i = arv; slv_ar_id_i = arid; slv_aw_valid_i = awv; slv_aw_id_i = awid;
    mst_r_valid_i = rv; mst_r_last_i = rv; mst_r_id_i = rid; mst_b_valid_i = bv; mst_b_id_i = bid;
    #2;
    s_ar_vld = mst_ar_valid_o; s_aw_vld = mst_aw_valid_o;
    s_ar_hs = mst_ar_valid_o & slv_ar_ready_o; s_aw_hs = mst_aw_valid_o & slv_aw_ready_o;
    s_ar_id = mst_ar_id_o; s_aw_id = mst_aw_id_o; s_r_id = slv_r_id_o; s_b_id = slv_b_id_o;
    @(posedge clk); #1;
    slv_ar_valid_i = 0; slv_aw_valid_i = 0; mst_r_valid_i = 0; mst_r_last_i = 0; mst_b_valid_i = 0;
  endtask

  task automatic test_reset();
    @(negedge clk); rst_i = 1; slv_ar_valid_i = 1; slv_ar_id_i = 6'h2A; slv_aw_valid_i = 1; slv_aw_id_i = 6'h13;
    #2;
    n_tests++; if (slv_ar_ready_o !== 1'b0 || mst_ar_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_ar got rdy=%b vld=%b exp 0 0", slv_ar_ready_o, mst_ar_valid_o); end
    n_tests++; if (slv_aw_ready_o !== 1'b0 || mst_aw_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_aw got rdy=%b vld=%b exp 0 0", slv_aw_ready_o, mst_aw_valid_o); end
    n_tests++; if (mst_ar_id_o !== 4'd0 || mst_aw_id_o !== 4'd0) begin n_fail++; $display("FAIL reset_mst_id got ar=%h aw=%h exp 0 0", mst_ar_id_o, mst_aw_id_o); end
    n_tests++; if (slv_r_id_o !== 6'd0 || slv_b_id_o !== 6'd0) begin n_fail++; $display("FAIL reset_rsp_id got r=%h b=%h exp 0 0", slv_r_id_o, slv_b_id_o); end
    do_reset();
  endtask

  task automatic test_basic_read();
    do_reset();
    exp_q.push_back(4'd0);
    cyc(1, 6'h2A, 0, 0, 0, 0, 0, 0);
    e = exp_q.pop_front();
    n_tests++; if (s_ar_hs !== 1'b1 || s_ar_id !== e) begin n_fail++; $display("FAIL basic_ar got hs=%b id=%h exp 1 %h", s_ar_hs, s_ar_id, e); end
    cyc(0, 0, 0, 0, 1, 4'd0, 0, 0);
    n_tests++; if (s_r_id !== 6'h2A) begin n_fail++; $display("FAIL basic_r_restore got %h exp 2a", s_r_id); end
    exp_q.push_back(4'd0);
    cyc(1, 6'h15, 0, 0, 0, 0, 0, 0);
    e = exp_q.pop_front();
    n_tests++; if (s_ar_hs !== 1'b1 || s_ar_id !== e) begin n_fail++; $display("FAIL basic_slot_freed got hs=%b id=%h exp 1 %h", s_ar_hs, s_ar_id, e); end
  endtask

  task automatic test_same_id();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(4'd0);
      cyc(1, 6'h05, 0, 0, 0, 0, 0, 0);
      e = exp_q.pop_front();
      n_tests++; if (s_ar_hs !== 1'b1 || s_ar_id !== e) begin n_fail++; $display("FAIL same_id_%0d got hs=%b id=%h exp 1 %h", k, s_ar_hs, s_ar_id, e); end
    end
    exp_q.push_back(4'd1);
    cyc(1, 6'h07, 0, 0, 0, 0, 0, 0);
    e = exp_q.pop_front();
    n_tests++; if (s_ar_hs !== 1'b1 || s_ar_id !== e) begin n_fail++; $display("FAIL same_id_new got hs=%b id=%h exp 1 %h", s_ar_hs, s_ar_id, e); end
    repeat (2) cyc(0, 0, 0, 0, 1, 4'd0, 0, 0);
    n_tests++; if (s_r_id !== 6'h05) begin n_fail++; $display("FAIL same_id_restore got %h exp 05", s_r_id); end
    exp_q.push_back(4'd2);
    cyc(1, 6'h09, 0, 0, 0, 0, 0, 0);
    e = exp_q.pop_front();
    n_tests++; if (s_ar_hs !== 1'b1 || s_ar_id !== e) begin n_fail++; $display("FAIL same_id_count_left got hs=%b id=%h exp 1 %h", s_ar_hs, s_ar_id, e); end
    cyc(0, 0, 0, 0, 1, 4'd0, 0, 0);
    exp_q.push_back(4'd0);
    cyc(1, 6'h0B, 0, 0, 0, 0, 0, 0);
    e = exp_q.pop_front();
    n_tests++; if (s_ar_hs !== 1'b1 || s_ar_id !== e) begin n_fail++; $display("FAIL same_id_drained got hs=%b id=%h exp 1 %h", s_ar_hs, s_ar_id, e); end
  endtask

  task automatic test_exhaust();
    int bad = 0;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      exp_q.push_back(4'(k));
      cyc(1, 6'h20 + 6'(k), 1, 6'h20 + 6'(k), 0, 0, 0, 0);
      e = exp_q.pop_front();
      if (!s_ar_hs || !s_aw_hs || s_ar_id !== e || s_aw_id !== e) bad++;
    end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL exhaust_fill got %0d bad grants exp 0", bad); end
    cyc(1, 6'h3F, 1, 6'h3F, 0, 0, 0, 0);
    n_tests++; if (s_ar_hs !== 1'b0 || s_ar_vld !== 1'b0) begin n_fail++; $display("FAIL exhaust_ar_stall got hs=%b vld=%b exp 0 0", s_ar_hs, s_ar_vld); end
    n_tests++; if (s_aw_hs !== 1'b0 || s_aw_vld !== 1'b0) begin n_fail++; $display("FAIL exhaust_aw_stall got hs=%b vld=%b exp 0 0", s_aw_hs, s_aw_vld); end
    cyc(1, 6'h3F, 1, 6'h3F, 1, 4'd4, 1, 4'd4);
    n_tests++; if (s_r_id !== 6'h24 || s_b_id !== 6'h24) begin n_fail++; $display("FAIL exhaust_restore got r=%h b=%h exp 24 24", s_r_id, s_b_id); end
    n_tests++; if (s_ar_hs !== 1'b0 || s_aw_hs !== 1'b0) begin n_fail++; $display("FAIL exhaust_same_cycle got ar=%b aw=%b exp 0 0", s_ar_hs, s_aw_hs); end
    exp_q.push_back(4'd4);
    cyc(1, 6'h3F, 1, 6'h3F, 0, 0, 0, 0);
    e = exp_q.pop_front();
    n_tests++; if (s_ar_hs !== 1'b1 || s_ar_id !== e) begin n_fail++; $display("FAIL exhaust_ar_grant got hs=%b id=%h exp 1 %h", s_ar_hs, s_ar_id, e); end
    n_tests++; if (s_aw_hs !== 1'b1 || s_aw_id !== e) begin n_fail++; $display("FAIL exhaust_aw_grant got hs=%b id=%h exp 1 %h", s_aw_hs, s_aw_id, e); end
  endtask

  task automatic test_saturation();
    int bad = 0;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back(4'd0);
      cyc(1, 6'h11, 1, 6'h11, 0, 0, 0, 0);
      e = exp_q.pop_front();
      if (!s_ar_hs || !s_aw_hs || s_ar_id !== e || s_aw_id !== e) bad++;
    end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL sat_fill got %0d bad grants exp 0", bad); end
    cyc(1, 6'h11, 1, 6'h11, 0, 0, 0, 0);
    n_tests++; if (s_ar_hs !== 1'b0 || s_aw_hs !== 1'b0) begin n_fail++; $display("FAIL sat_stall got ar=%b aw=%b exp 0 0", s_ar_hs, s_aw_hs); end
    cyc(1, 6'h11, 1, 6'h11, 1, 4'd0, 1, 4'd0);
    n_tests++; if (s_ar_hs !== 1'b0 || s_aw_hs !== 1'b0) begin n_fail++; $display("FAIL sat_release_cycle got ar=%b aw=%b exp 0 0", s_ar_hs, s_aw_hs); end
    exp_q.push_back(4'd0);
    cyc(1, 6'h11, 1, 6'h11, 0, 0, 0, 0);
    e = exp_q.pop_front();
    n_tests++; if (s_ar_hs !== 1'b1 || s_ar_id !== e || s_aw_hs !== 1'b1 || s_aw_id !== e) begin n_fail++; $display("FAIL sat_regrant got ar=%b/%h aw=%b/%h exp 1/%h", s_ar_hs, s_ar_id, s_aw_hs, s_aw_id, e); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    cyc(1, 6'h05, 1, 6'h05, 0, 0, 0, 0);
    exp_q.push_back(4'd0);
    cyc(1, 6'h05, 1, 6'h05, 1, 4'd0, 1, 4'd0);
    e = exp_q.pop_front();
    n_tests++; if (s_ar_hs !== 1'b1 || s_ar_id !== e || s_aw_hs !== 1'b1 || s_aw_id !== e) begin n_fail++; $display("FAIL simul_hit got ar=%b/%h aw=%b/%h exp 1/%h", s_ar_hs, s_ar_id, s_aw_hs, s_aw_id, e); end
    n_tests++; if (s_r_id !== 6'h05 || s_b_id !== 6'h05) begin n_fail++; $display("FAIL simul_restore got r=%h b=%h exp 05 05", s_r_id, s_b_id); end
    exp_q.push_back(4'd1);
    cyc(1, 6'h07, 1, 6'h07, 0, 0, 0, 0);
    e = exp_q.pop_front();
    n_tests++; if (s_ar_id !== e || s_aw_id !== e || !s_ar_hs || !s_aw_hs) begin n_fail++; $display("FAIL simul_still_valid got ar=%h aw=%h exp %h", s_ar_id, s_aw_id, e); end
    cyc(0, 0, 0, 0, 1, 4'd0, 1, 4'd0);
    exp_q.push_back(4'd0);
    cyc(1, 6'h09, 1, 6'h09, 0, 0, 0, 0);
    e = exp_q.pop_front();
    n_tests++; if (s_ar_id !== e || s_aw_id !== e || !s_ar_hs || !s_aw_hs) begin n_fail++; $display("FAIL simul_count_one got ar=%h aw=%h exp %h", s_ar_id, s_aw_id, e); end
  endtask

`ifdef DRAM_ID_REMAP_CALIB_GATE_EN
  task automatic test_calib_gate();
    int hs_cnt = 0, bad = 0;
    calib_done_i = 0;
    do_reset();
    for (int k = 0; k < 100; k++) begin
      cyc(1, 6'h2A, 1, 6'h2A, 0, 0, 0, 0);
      if (s_ar_hs || s_aw_hs) hs_cnt++;
    end
    n_tests++; if (hs_cnt != 0) begin n_fail++; $display("FAIL calib_blocked got %0d handshakes exp 0", hs_cnt); end
    @(negedge clk); calib_done_i = 1;
    @(negedge clk); calib_done_i = 0;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(4'd0);
      cyc(1, 6'h2A, 1, 6'h2A, 0, 0, 0, 0);
      e = exp_q.pop_front();
      if (!s_ar_hs || !s_aw_hs || s_ar_id !== e) bad++;
    end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL calib_sticky got %0d missed grants exp 0", bad); end
    calib_done_i = 1;
  endtask
`endif

  initial begin
    test_reset();
    test_basic_read();
    test_same_id();
    test_exhaust();
    test_saturation();
    test_simultaneous();
`ifdef DRAM_ID_REMAP_CALIB_GATE_EN
    test_calib_gate();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
